bin_to_7seg_scan: RTL and testbench

- Multi-digit, time-multiplexed 7-segment display driver; successor to the single-digit combinational BCD decoder.
- Accepts an unsigned binary value on a load strobe and converts it to BCD sequentially (shift-and-add-3, one bit per clock).
- Latches the result into a display register and scans the digits onto one shared segment bus with per-digit active-low enables.
- Sits between the datapath that produces the value and the board display pins.

---
 rtl/bin_to_7seg_scan.sv | 169 ++++++++++++++++
 tb/tb_bin_to_7seg_scan.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/bin_to_7seg_scan.sv
// Multi-digit time-multiplexed 7-segment driver with sequential binary-to-BCD conversion.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 always shown).
module bin_to_7seg_scan #(
  parameter int DIGITS   = 4,
  parameter int BIN_W    = 14,
  parameter int SCAN_DIV = 50000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [BIN_W-1:0]  bin_in,
  input  logic              load,
  output logic              busy,
  output logic              done,
  output logic              ovf,
  output logic [6:0]        seg,
  output logic [DIGITS-1:0] an
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CW    = $clog2(BIN_W + 1);
  localparam int PW    = $clog2(SCAN_DIV);
  localparam int IW    = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  function automatic logic [31:0] pow10(input int n);
    logic [31:0] p;
    p = 32'd1;
    for (int i = 0; i < n; i++) p = p * 32'd10;
    return p;
  endfunction

  localparam logic [31:0] LIMIT = pow10(DIGITS);

  function automatic logic [6:0] decode(input logic [3:0] n);
    case (n)
      4'd0:    return 7'h7E;
      4'd1:    return 7'h30;
      4'd2:    return 7'h6D;
      4'd3:    return 7'h79;
      4'd4:    return 7'h33;
      4'd5:    return 7'h5B;
      4'd6:    return 7'h5F;
      4'd7:    return 7'h70;
      4'd8:    return 7'h7F;
      4'd9:    return 7'h7B;
      4'hF:    return 7'h01;
      default: return 7'h00;
    endcase
  endfunction

  function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    r = b;
    for (int i = 0; i < DIGITS; i++)
      if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
    return r;
  endfunction

  typedef enum logic [1:0] {IDLE, CONV, UPDATE} state_t;

  state_t            state_q, state_d;
  logic [BIN_W-1:0]  bin_q, bin_d;
  logic [BCD_W-1:0]  bcd_q, bcd_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              ovfp_q, ovfp_d;
  logic [BCD_W-1:0]  disp_q, disp_d;
  logic              ovf_q, ovf_d;
  logic [PW-1:0]     presc_q;
  logic [IW-1:0]     idx_q;
  logic [6:0]        seg_q, seg_d;
  logic [DIGITS-1:0] an_q, an_d;
  logic [3:0]        nib [DIGITS];
  logic [DIGITS-1:0] blank;

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    ovfp_d  = ovfp_q;
    disp_d  = disp_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (load) begin
          bin_d   = bin_in;
          bcd_d   = '0;
          cnt_d   = '0;
          ovfp_d  = ({{(32-BIN_W){1'b0}}, bin_in} >= LIMIT);
          state_d = CONV;
        end
      end
      CONV: begin
        // Top-nibble carries fall off the end; the overflow flag already covers them.
        {bcd_d, bin_d} = {add3(bcd_q), bin_q} << 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(BIN_W - 1)) state_d = UPDATE;
      end
      UPDATE: begin
        disp_d  = ovfp_q ? '1 : bcd_q;
        ovf_d   = ovfp_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    for (int i = 0; i < DIGITS; i++) nib[i] = disp_q[4*i +: 4];
  end

`ifdef LEADING_ZERO_BLANK_EN
  always_comb begin
    logic zero_hi;
    zero_hi = 1'b1;
    blank   = '0;
    for (int i = DIGITS - 1; i > 0; i--) begin
      zero_hi  = zero_hi & (nib[i] == 4'd0);
      blank[i] = zero_hi;
    end
  end
`else
  assign blank = '0;
`endif

  always_comb begin
    seg_d = blank[idx_q] ? 7'h00 : decode(nib[idx_q]);
    an_d  = ~(DIGITS'(1) << idx_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      ovfp_q  <= 1'b0;
      disp_q  <= '0;
      ovf_q   <= 1'b0;
      presc_q <= '0;
      idx_q   <= '0;
      seg_q   <= 7'h00;
      an_q    <= '1;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      ovfp_q  <= ovfp_d;
      disp_q  <= disp_d;
      ovf_q   <= ovf_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
      // Scan runs freely, unaffected by the conversion FSM.
      if (presc_q == PW'(SCAN_DIV - 1)) begin
        presc_q <= '0;
        idx_q   <= (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
      end else begin
        presc_q <= presc_q + 1'b1;
      end
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == UPDATE);
  assign ovf  = ovf_q;
  assign seg  = seg_q;
  assign an   = an_q;

endmodule

// File: tb/tb_bin_to_7seg_scan.sv
// Self-checking bench for bin_to_7seg_scan: vector table, random values and
// hand-written reset / back-to-back sequences against a decimal-digit model.
module tb_bin_to_7seg_scan;

  localparam int DIGITS   = 4;
  localparam int BIN_W    = 14;
  localparam int SCAN_DIV = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [BIN_W-1:0]  bin_in;
  logic              load;
  logic              busy, done, ovf;
  logic [6:0]        seg;
  logic [DIGITS-1:0] an;

  int n_checks = 0;
  int n_fail   = 0;

  logic [6:0] pat [0:9] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33,
                            7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B};

  typedef struct {
    int v;
    bit ovf;
  } vec_t;

  vec_t tbl [8];

  bin_to_7seg_scan #(.DIGITS(DIGITS), .BIN_W(BIN_W), .SCAN_DIV(SCAN_DIV)) dut (
    .clk(clk), .reset(reset), .bin_in(bin_in), .load(load),
    .busy(busy), .done(done), .ovf(ovf), .seg(seg), .an(an)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Segment pattern expected in digit slot k when value v is displayed.
  function automatic logic [6:0] exp_seg(input int v, input int k);
    int p;
    p = 1;
    for (int i = 0; i < k; i++) p = p * 10;
    if (v >= 10000) return 7'h01;
`ifdef LEADING_ZERO_BLANK_EN
    if (k > 0 && v < p) return 7'h00;
`endif
    return pat[(v / p) % 10];
  endfunction

  task automatic check_scan(input int v, input string name);
    logic [DIGITS-1:0] seen;
    int idx;
    seen = '0;
    for (int c = 0; c < 2 * DIGITS * SCAN_DIV; c++) begin
      tick();
      chk({name, "_onehot"}, $countones(~an), 1);
      idx = 0;
      for (int k = 0; k < DIGITS; k++) if (an[k] == 1'b0) idx = k;
      seen[idx] = 1'b1;
      chk({name, "_seg"}, {25'd0, seg}, {25'd0, exp_seg(v, idx)});
    end
    chk({name, "_all_slots"}, {28'd0, seen}, 32'hF);
  endtask

  task automatic do_conv(input int v, input bit exp_ovf, input bit glitch, input string name);
    int busy_n, done_n, done_at;
    busy_n  = 0;
    done_n  = 0;
    done_at = -1;
    bin_in  = v[BIN_W-1:0];
    load    = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (c == 1) load = 1'b0;
      if (glitch && c == 5) begin
        bin_in = 14'($urandom_range(0, 16383));
        load   = 1'b1;
      end
      if (glitch && c == 6) load = 1'b0;
      if (busy === 1'b1) busy_n++;
      if (done === 1'b1) begin
        done_n++;
        done_at = c;
      end
    end
    chk({name, "_busy_cycles"}, busy_n, 15);
    chk({name, "_done_count"}, done_n, 1);
    chk({name, "_done_at"}, done_at, 15);
    chk({name, "_ovf"}, {31'd0, ovf}, {31'd0, exp_ovf});
    check_scan(v, name);
  endtask

  initial begin
    tbl[0] = '{1234, 1'b0};
    tbl[1] = '{9999, 1'b0};
    tbl[2] = '{10000, 1'b1};
    tbl[3] = '{5, 1'b0};
    tbl[4] = '{0, 1'b0};
    tbl[5] = '{7, 1'b0};
    tbl[6] = '{16383, 1'b1};
    tbl[7] = '{1000, 1'b0};

    reset  = 1'b0;
    load   = 1'b0;
    bin_in = '0;
    tick();
    tick();
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_ovf", {31'd0, ovf}, 0);
    chk("rst_an", {28'd0, an}, 32'hF);
    chk("rst_seg", {25'd0, seg}, 0);
    reset = 1'b1;
    for (int j = 0; j < 4 * DIGITS * SCAN_DIV; j++) begin
      tick();
      chk("walk_an", {28'd0, an}, {28'd0, ~(4'b0001 << ((j / SCAN_DIV) % DIGITS))});
      if (j == 0) chk("first_seg", {25'd0, seg}, 32'h7E);
    end

    for (int t = 0; t < 8; t++) do_conv(tbl[t].v, tbl[t].ovf, 1'b0, "table");

    begin : back_to_back
      int done_n, done_at2;
      done_n   = 0;
      done_at2 = -1;
      bin_in   = 14'd42;
      load     = 1'b1;
      for (int c = 1; c <= 40; c++) begin
        tick();
        if (done === 1'b1) begin
          done_n++;
          if (c > 15) done_at2 = c;
        end
        if (c == 15) chk("b2b_first_done", {31'd0, done}, 1);
        if (c == 16) chk("b2b_gap_busy", {31'd0, busy}, 0);
        if (c == 17) begin
          chk("b2b_second_busy", {31'd0, busy}, 1);
          load = 1'b0;
        end
      end
      chk("b2b_done_count", done_n, 2);
      chk("b2b_second_done_at", done_at2, 31);
      check_scan(42, "b2b");
    end

    for (int r = 0; r < 20; r++) begin
      int v;
      v = $urandom_range(0, 16383);
      do_conv(v, v >= 10000, 1'b1, "rand");
    end

    do_conv(10000, 1'b1, 1'b0, "pre_abort");
    bin_in = 14'd8888;
    load   = 1'b1;
    tick();
    load = 1'b0;
    for (int c = 0; c < 5; c++) tick();
    chk("abort_busy_before", {31'd0, busy}, 1);
    reset = 1'b0;
    #1;
    chk("abort_busy", {31'd0, busy}, 0);
    chk("abort_done", {31'd0, done}, 0);
    chk("abort_ovf", {31'd0, ovf}, 0);
    chk("abort_an", {28'd0, an}, 32'hF);
    chk("abort_seg", {25'd0, seg}, 0);
    tick();
    reset = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      chk("abort_no_done", {31'd0, done}, 0);
    end
    chk("abort_ovf_after", {31'd0, ovf}, 0);
    check_scan(0, "abort");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
